fp_addmul_pipelined: RTL and testbench
======================================

Name: fp_addmul_pipelined

Overview:
- Parametrised, pipelined floating-point arithmetic unit with run-time selection of add, subtract or multiply.
- Generalises the combinational single-precision adder/multiplier pair into one valid/ready streaming block with configurable exponent and mantissa widths.
- Fixed latency of 3 cycles; raises IEEE-style exception flags.
- Sits between an operand FIFO and a result writeback stage.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width, hidden bit excluded (>=2)
(derived) W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1

Ports:
i_clk  in  1  clock, rising edge
i_RESET  in  1  synchronous reset, active-high
i_valid  in  1  operand beat valid
o_ready  out  1  block accepts a beat this cycle
i_op  in  2  00 add, 01 sub (A-B), 10 mul, 11 reserved
i_A  in  W  operand A
i_B  in  W  operand B
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_result  out  W  result
o_overflow  out  1  result overflowed to infinity
o_underflow  out  1  result flushed to zero from a nonzero exact value
o_invalid  out  1  invalid operation; result is canonical NaN

Behaviour:
- Reset (i_RESET high at a rising edge):
  - All stage valid bits clear; o_valid=0.
  - o_result and all flags = 0.
  - In-flight beats are discarded, including beats mid-pipeline.
  - o_ready=1 in the first cycle after reset.
- Pipeline structure:
  - Three register stages: S1 decode/align or multiply, S2 add/normalise, S3 pack/flags.
  - advance = !o_valid | i_ready; o_ready = advance.
  - All stages shift together when advance=1 and hold when advance=0.
  - Bubbles are not collapsed.
- Handshake:
  - A beat is accepted when i_valid & o_ready at a rising edge.
  - With no stall, a beat accepted at edge N appears with o_valid=1 after edge N+3.
  - Throughput is 1 beat/cycle.
  - o_result and flags stay stable while o_valid & !i_ready.
- Operand decoding:
  - Exponent 0 = zero; denormals are flushed to zero with sign kept.
  - Exponent all-ones with mantissa 0 = infinity.
  - Exponent all-ones with mantissa nonzero = NaN.
- Canonical NaN: sign 0, exponent all-ones, mantissa MSB 1, remaining bits 0.
- Special cases, in priority order:
  - op=11 -> canonical NaN, invalid=1.
  - Any NaN input -> canonical NaN, invalid=1.
  - inf-inf (effective subtraction) or inf*0 -> canonical NaN, invalid=1.
  - inf op finite -> correctly signed inf; flags clear.
  - Zero operand in add: result is the other operand. (+0)+(-0) = +0; (-0)+(-0) = -0.
  - Zero operand in mul: result is signed zero (sign = sA^sB).
- Sub: implemented as add with B sign inverted.
- Add path:
  - Swap so the larger magnitude is first.
  - Align the smaller mantissa by the exponent difference, clamped to MAN_W+3.
  - Add or subtract with 2 guard bits.
  - Normalise: right shift 1 on carry, or left shift by leading-zero count.
  - Exact cancellation -> +0, no flags.
- Mul path:
  - (MAN_W+1)x(MAN_W+1) mantissa product.
  - Exponent = eA+eB-BIAS, computed in EXP_W+2 signed bits.
  - Normalise by at most 1 right shift.
- Rounding: truncate (round toward zero) in all cases.
- Exponent range:
  - Final biased exponent >= all-ones -> signed infinity, overflow=1.
  - Final biased exponent <= 0 -> signed zero, underflow=1.
- Flags are per-beat and valid only with o_valid.

Test Plan:
- Reset, then add 0x3F800000 + 0x40000000 (EXP_W=8, MAN_W=23) -> 0x40400000 exactly 3 cycles after acceptance, flags 0.
- mul 0x3FC00000 * 0x40000000 -> 0x40400000. sub 0x40400000 - 0x40400000 -> 0x00000000, no flags.
- mul 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1. mul 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- sub 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1. op=11 with any operands -> 0x7FC00000, invalid=1.
- Stream 10 back-to-back beats with i_ready toggling 1,0,0,1,...:
  - Results appear in order with no loss or duplication.
  - o_result is stable while stalled.
  - o_ready = !o_valid | i_ready every cycle.
- Assert i_RESET with 3 beats in flight -> o_valid=0 the next cycle; none of the 3 results ever appear. Repeat the first scenario at EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 -> 0x4200.

Source files
------------

// File: rtl/fp_addmul_pipelined.sv
// -----------------------------------------------------------------------------
// fp_addmul_pipelined
//
// Streaming floating-point add / subtract / multiply unit. The exponent and
// mantissa widths are parameters. Results are truncated (round toward zero),
// denormal operands are flushed to zero, and overflow, underflow and invalid
// flags are raised for each beat.
//
// Pipeline: operand capture -> S1 decode/align or multiply -> S2 add/normalise
// -> S3 pack/flags. A beat accepted at edge N is presented after edge N+3.
// All stages advance together whenever the output is empty or being consumed.
//
// Ports:
//   i_clk        clock, rising edge
//   i_RESET      synchronous active-high reset; flushes every stage
//   i_valid      operand beat valid
//   o_ready      beat is accepted this cycle (= !o_valid | i_ready)
//   i_op         00 add, 01 sub (A-B), 10 mul, 11 reserved (gives invalid)
//   i_A, i_B     operands {sign, exponent, mantissa}
//   o_valid      result valid
//   i_ready      downstream accepts the result
//   o_result     result word
//   o_overflow   result saturated to infinity
//   o_underflow  nonzero result flushed to zero
//   o_invalid    invalid operation; o_result is the canonical NaN
// -----------------------------------------------------------------------------
module fp_addmul_pipelined #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_clk,
  input  logic                 i_RESET,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_op,
  input  logic [EXP_W+MAN_W:0] i_A,
  input  logic [EXP_W+MAN_W:0] i_B,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [EXP_W+MAN_W:0] o_result,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_invalid
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 1;                         // mantissa incl. hidden bit
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int XW    = EXP_W + $clog2(MAN_W + 4) + 2;     // room for lzc subtraction
  localparam int LZW   = $clog2(M + 3) + 1;
  localparam int SHMAX = MAN_W + 3;
  localparam int PW    = MAN_W + 2;                         // kept product bits
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  logic w_advance;
  assign w_advance = !o_valid || i_ready;
  assign o_ready   = w_advance;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  logic         r0_valid;
  logic [1:0]   r0_op;
  logic [W-1:0] r0_a, r0_b;

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      r0_valid <= 1'b0;
      r0_op    <= '0;
      r0_a     <= '0;
      r0_b     <= '0;
    end else if (w_advance) begin
      r0_valid <= i_valid;
      r0_op    <= i_op;
      r0_a     <= i_A;
      r0_b     <= i_B;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: decode, special cases, swap/align for add, mantissa product for mul
  // ---------------------------------------------------------------------------
  logic [W-1:0]     w_opnd [2];
  logic             w_sgn  [2];
  logic [EXP_W-1:0] w_exp  [2];
  logic [MAN_W-1:0] w_frac [2];
  logic             w_zero [2];
  logic             w_inf  [2];
  logic             w_nan  [2];

  assign w_opnd[0] = r0_a;
  assign w_opnd[1] = r0_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dec
    assign w_sgn[gi]  = w_opnd[gi][W-1];
    assign w_exp[gi]  = w_opnd[gi][W-2 -: EXP_W];
    assign w_frac[gi] = w_opnd[gi][MAN_W-1:0];
    // exponent 0 covers both true zero and flushed denormals
    assign w_zero[gi] = (w_exp[gi] == '0);
    assign w_inf[gi]  = (w_exp[gi] == '1) && (w_frac[gi] == '0);
    assign w_nan[gi]  = (w_exp[gi] == '1) && (w_frac[gi] != '0);
  end

  logic w_is_mul, w_sbe, w_smul;
  assign w_is_mul = (r0_op == 2'b10);
  assign w_sbe    = w_sgn[1] ^ (r0_op == 2'b01);   // subtract = add with B negated
  assign w_smul   = w_sgn[0] ^ w_sgn[1];

  logic         w_spec, w_spec_inv;
  logic [W-1:0] w_spec_res;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = '0;
    if (r0_op == 2'b11 || w_nan[0] || w_nan[1]) begin
      w_spec_res = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_is_mul) begin
      if ((w_inf[0] && w_zero[1]) || (w_zero[0] && w_inf[1])) begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end else if (w_inf[0] || w_inf[1]) begin
        w_spec_res = {w_smul, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_zero[0] || w_zero[1]) begin
        w_spec_res = {w_smul, {(W-1){1'b0}}};
      end else begin
        w_spec = 1'b0;
      end
    end else begin
      if (w_inf[0] && w_inf[1] && (w_sgn[0] != w_sbe)) begin
        w_spec_res = QNAN;
        w_spec_inv = 1'b1;
      end else if (w_inf[0]) begin
        w_spec_res = {w_sgn[0], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_inf[1]) begin
        w_spec_res = {w_sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_zero[0] && w_zero[1]) begin
        // only (-0)+(-0) keeps a negative sign
        w_spec_res = {w_sgn[0] & w_sbe, {(W-1){1'b0}}};
      end else if (w_zero[0]) begin
        w_spec_res = {w_sbe, w_exp[1], w_frac[1]};
      end else if (w_zero[1]) begin
        w_spec_res = {w_sgn[0], w_exp[0], w_frac[0]};
      end else begin
        w_spec = 1'b0;
      end
    end
  end

  // Add path: larger magnitude first so the difference never goes negative.
  logic             w_a_ge_b, w_sl, w_ss;
  logic [EXP_W-1:0] w_el, w_es;
  logic [MAN_W-1:0] w_fl, w_fs;
  logic [XW-1:0]    w_diff, w_shamt;
  logic [M+1:0]     w_ml_ext, w_ms_ext, w_ms_al;

  assign w_a_ge_b = {w_exp[0], w_frac[0]} >= {w_exp[1], w_frac[1]};
  assign w_el     = w_a_ge_b ? w_exp[0]  : w_exp[1];
  assign w_es     = w_a_ge_b ? w_exp[1]  : w_exp[0];
  assign w_fl     = w_a_ge_b ? w_frac[0] : w_frac[1];
  assign w_fs     = w_a_ge_b ? w_frac[1] : w_frac[0];
  assign w_sl     = w_a_ge_b ? w_sgn[0]  : w_sbe;
  assign w_ss     = w_a_ge_b ? w_sbe     : w_sgn[0];
  assign w_diff   = XW'(w_el) - XW'(w_es);
  // past MAN_W+3 every bit of the smaller operand is shifted out anyway
  assign w_shamt  = (w_diff > XW'(SHMAX)) ? XW'(SHMAX) : w_diff;
  assign w_ml_ext = {1'b1, w_fl, 2'b00};
  assign w_ms_ext = {1'b1, w_fs, 2'b00};
  assign w_ms_al  = w_ms_ext >> w_shamt;

  // Mul path
  logic [2*M-1:0] w_prod;
  logic [XW-1:0]  w_mexp;
  assign w_prod = {{M{1'b0}}, 1'b1, w_frac[0]} * {{M{1'b0}}, 1'b1, w_frac[1]};
  assign w_mexp = XW'(w_exp[0]) + XW'(w_exp[1]) - XW'(BIAS);

  logic          r1_valid, r1_mul, r1_spec, r1_spec_inv, r1_sign, r1_sub;
  logic [W-1:0]  r1_spec_res;
  logic [XW-1:0] r1_exp;
  logic [M+1:0]  r1_ml, r1_ms;
  logic [PW-1:0] r1_prod;

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      r1_valid    <= 1'b0;
      r1_mul      <= 1'b0;
      r1_spec     <= 1'b0;
      r1_spec_inv <= 1'b0;
      r1_spec_res <= '0;
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_exp      <= '0;
      r1_ml       <= '0;
      r1_ms       <= '0;
      r1_prod     <= '0;
    end else if (w_advance) begin
      r1_valid    <= r0_valid;
      r1_mul      <= w_is_mul;
      r1_spec     <= w_spec;
      r1_spec_inv <= w_spec_inv;
      r1_spec_res <= w_spec_res;
      r1_sign     <= w_is_mul ? w_smul : w_sl;
      r1_sub      <= w_sl ^ w_ss;
      r1_exp      <= w_is_mul ? w_mexp : XW'(w_el);
      r1_ml       <= w_ml_ext;
      r1_ms       <= w_ms_al;
      // only the top bits of the product survive truncation
      r1_prod     <= PW'(w_prod >> (2*M - PW));
    end
  end

  // ---------------------------------------------------------------------------
  // S2: add/subtract and normalise
  // ---------------------------------------------------------------------------
  logic [M+2:0]     w_sum;
  logic [LZW-1:0]   w_lzc;
  logic [MAN_W-1:0] w_norm_man;
  logic [MAN_W-1:0] w_s2_man;
  logic [XW-1:0]    w_s2_exp;
  logic             w_s2_zero;

  assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                        : ({1'b0, r1_ml} + {1'b0, r1_ms});

  // leading-zero count of the non-carry part; the highest set bit wins
  always_comb begin
    w_lzc = LZW'(M + 2);
    for (int i = 0; i < M + 2; i++) begin
      if (w_sum[i]) w_lzc = LZW'(M + 1 - i);
    end
  end

  // after the left shift the hidden bit sits at M+1; stored bits are [M:2]
  assign w_norm_man = MAN_W'((w_sum[M+1:0] << w_lzc) >> 2);

  always_comb begin
    w_s2_man  = '0;
    w_s2_exp  = r1_exp;
    w_s2_zero = 1'b0;
    if (r1_mul) begin
      if (r1_prod[PW-1]) begin
        w_s2_man = r1_prod[PW-2:1];
        w_s2_exp = r1_exp + XW'(1);
      end else begin
        w_s2_man = r1_prod[PW-3:0];
      end
    end else if (w_sum == '0) begin
      w_s2_zero = 1'b1;                 // exact cancellation -> +0
    end else if (w_sum[M+2]) begin
      w_s2_man = w_sum[M+1:3];
      w_s2_exp = r1_exp + XW'(1);
    end else begin
      w_s2_man = w_norm_man;
      w_s2_exp = r1_exp - XW'(w_lzc);
    end
  end

  logic             r2_valid, r2_spec, r2_spec_inv, r2_sign, r2_zero;
  logic [W-1:0]     r2_spec_res;
  logic [XW-1:0]    r2_exp;
  logic [MAN_W-1:0] r2_man;

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      r2_valid    <= 1'b0;
      r2_spec     <= 1'b0;
      r2_spec_inv <= 1'b0;
      r2_spec_res <= '0;
      r2_sign     <= 1'b0;
      r2_zero     <= 1'b0;
      r2_exp      <= '0;
      r2_man      <= '0;
    end else if (w_advance) begin
      r2_valid    <= r1_valid;
      r2_spec     <= r1_spec;
      r2_spec_inv <= r1_spec_inv;
      r2_spec_res <= r1_spec_res;
      r2_sign     <= r1_sign;
      r2_zero     <= w_s2_zero;
      r2_exp      <= w_s2_exp;
      r2_man      <= w_s2_man;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: exponent range check, pack, flags
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_s3_res;
  logic         w_s3_ovf, w_s3_unf, w_s3_inv;

  always_comb begin
    w_s3_res = {r2_sign, r2_exp[EXP_W-1:0], r2_man};
    w_s3_ovf = 1'b0;
    w_s3_unf = 1'b0;
    w_s3_inv = 1'b0;
    if (r2_spec) begin
      w_s3_res = r2_spec_res;
      w_s3_inv = r2_spec_inv;
    end else if (r2_zero) begin
      w_s3_res = '0;
    end else if ($signed(r2_exp) >= EMAX) begin
      w_s3_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_s3_ovf = 1'b1;
    end else if (r2_exp[XW-1] || r2_exp == '0) begin
      w_s3_res = {r2_sign, {(W-1){1'b0}}};
      w_s3_unf = 1'b1;
    end
  end

  logic         r3_valid, r3_ovf, r3_unf, r3_inv;
  logic [W-1:0] r3_res;

  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      r3_valid <= 1'b0;
      r3_res   <= '0;
      r3_ovf   <= 1'b0;
      r3_unf   <= 1'b0;
      r3_inv   <= 1'b0;
    end else if (w_advance) begin
      r3_valid <= r2_valid;
      r3_res   <= w_s3_res;
      r3_ovf   <= w_s3_ovf;
      r3_unf   <= w_s3_unf;
      r3_inv   <= w_s3_inv;
    end
  end

  assign o_valid     = r3_valid;
  assign o_result    = r3_res;
  assign o_overflow  = r3_ovf;
  assign o_underflow = r3_unf;
  assign o_invalid   = r3_inv;

endmodule

// File: tb/tb_fp_addmul_pipelined.sv
// Directed testbench for fp_addmul_pipelined (single precision plus one
// half-precision instance).
module tb_fp_addmul_pipelined;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_valid, i_ready;
  logic [1:0]  op;
  logic [31:0] a, b, res;
  logic        o_ready, o_valid, ovf, unf, inv;

  logic        h_valid;
  logic [15:0] ha, hb, hres;
  logic        h_oready, h_ovalid, h_ovf, h_unf, h_inv;

  fp_addmul_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk(clk), .i_RESET(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(op), .i_A(a), .i_B(b), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(res), .o_overflow(ovf), .o_underflow(unf), .o_invalid(inv)
  );

  fp_addmul_pipelined #(.EXP_W(5), .MAN_W(10)) dut_h (
    .i_clk(clk), .i_RESET(rst), .i_valid(h_valid), .o_ready(h_oready),
    .i_op(2'b00), .i_A(ha), .i_B(hb), .o_valid(h_ovalid), .i_ready(1'b1),
    .o_result(hres), .o_overflow(h_ovf), .o_underflow(h_unf), .o_invalid(h_inv)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One isolated beat with i_ready high; checks latency, result and flags.
  // Flag vector order is {overflow, underflow, invalid}.
  task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] res_e, input logic [2:0] fl_e);
    int lat;
    @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    op = op_i;
    a = a_i;
    b = b_i;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 32'd3);
    check({tag, " valid"}, {31'b0, o_valid}, 32'd1);
    check({tag, " result"}, res, res_e);
    check({tag, " flags"}, {29'b0, ovf, unf, inv}, {29'b0, fl_e});
    $display("op %b A=%h B=%h -> %h flags=%b%b%b", op_i, a_i, b_i, res, ovf, unf, inv);
  endtask

  logic [31:0] s_in  [10];
  logic [31:0] s_out [10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, rcvd, cyc, lat;
    logic prev_stall;
    logic [31:0] held;

    s_in  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    s_out = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000,
              32'h41400000, 32'h41600000, 32'h41800000, 32'h41900000, 32'h41A00000};

    // ---- reset ----
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    h_valid = 1'b0; ha = '0; hb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset valid", {31'b0, o_valid}, 32'd0);
    check("reset result", res, 32'd0);
    check("reset flags", {29'b0, ovf, unf, inv}, 32'd0);
    check("reset ready", {31'b0, o_ready}, 32'd1);
    check("reset half valid", {31'b0, h_ovalid}, 32'd0);

    // ---- directed single beats ----
    run_op("add 1+2",        2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
    run_op("mul 1.5*2",      2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    run_op("sub 3-3",        2'b01, 32'h40400000, 32'h40400000, 32'h00000000, 3'b000);
    run_op("mul ovf",        2'b10, 32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100);
    run_op("mul unf",        2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
    run_op("sub inf-inf",    2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001);
    run_op("op11",           2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h7FC00000, 3'b001);
    run_op("sub 1-2",        2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000);
    run_op("add x+0",        2'b00, 32'h40400000, 32'h00000000, 32'h40400000, 3'b000);
    run_op("add +0+-0",      2'b00, 32'h00000000, 32'h80000000, 32'h00000000, 3'b000);
    run_op("add -0+-0",      2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
    run_op("add inf+1",      2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
    run_op("mul -0*2",       2'b10, 32'h80000000, 32'h40000000, 32'h80000000, 3'b000);
    run_op("add nan",        2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001);
    run_op("add far",        2'b00, 32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000);
    run_op("add trunc",      2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000);
    run_op("mul neg",        2'b10, 32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000);
    run_op("mul inf*0",      2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
    run_op("add denorm",     2'b00, 32'h00400000, 32'h3F800000, 32'h3F800000, 3'b000);
    run_op("mul trunc",      2'b10, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run_op("add ovf",        2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100);
    run_op("sub unf",        2'b01, 32'h00800000, 32'h00C00000, 32'h80000000, 3'b010);

    // ---- streaming with i_ready pattern 1,0,0 ----
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    while (rcvd < 10 && cyc < 200) begin
      @(negedge clk);
      i_ready = (cyc % 3 == 0);
      i_valid = (sent < 10);
      op = 2'b00;
      a = (sent < 10) ? s_in[sent] : 32'h0;
      b = a;
      #1;
      check("stream ready", {31'b0, o_ready}, {31'b0, (!o_valid || i_ready)});
      if (prev_stall) begin
        check("stall valid", {31'b0, o_valid}, 32'd1);
        check("stall hold", res, held);
      end
      if (o_valid && i_ready) begin
        if (rcvd < 10) begin
          check("stream result", res, s_out[rcvd]);
          check("stream flags", {29'b0, ovf, unf, inv}, 32'd0);
          $display("stream beat %0d -> %h", rcvd, res);
        end else begin
          check("stream extra", {31'b0, o_valid}, 32'd0);
        end
        rcvd++;
      end
      if (i_valid && o_ready) sent++;
      prev_stall = o_valid && !i_ready;
      held = res;
      cyc++;
    end
    check("stream count", rcvd, 32'd10);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("stream drained", {31'b0, o_valid}, 32'd0);

    // ---- reset with three beats in flight ----
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1; op = 2'b00; a = 32'h3F800000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    op = 2'b10; a = 32'h3FC00000; b = 32'h40000000;
    @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("flush valid", {31'b0, o_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush stays empty", {31'b0, o_valid}, 32'd0);
    end
    $display("flush: no in-flight results emerged");

    // ---- half precision: 1.0 + 2.0 ----
    @(negedge clk);
    h_valid = 1'b1; ha = 16'h3C00; hb = 16'h4000;
    @(negedge clk);
    h_valid = 1'b0;
    lat = 0;
    while (!h_ovalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("half latency", lat, 32'd3);
    check("half result", {16'b0, hres}, 32'h00004200);
    check("half flags", {29'b0, h_ovf, h_unf, h_inv}, 32'd0);
    check("half ready", {31'b0, h_oready}, 32'd1);
    $display("half add 3C00+4000 -> %h", hres);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
